mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter STROBE_CYCLES, default 1, sets the number of cycles mem_enable is held high per access; legal range is 1..15.
REQ-002 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port req_valid, input, 1: CPU-side access request.
REQ-005 Port req_ready, output, 1: controller can accept a request.
REQ-006 Port req_rw, input, 1: 0 = read, 1 = write.
REQ-007 Port req_addr, input, 32: byte address.
REQ-008 Port req_wdata, input, 32: write data, right-aligned.
REQ-009 Port req_size, input, 2: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-010 Port req_signed, input, 1: sign-extend byte/halfword read data.
REQ-011 Port resp_valid, output, 1: one-cycle completion pulse.
REQ-012 Port resp_rdata, output, 32: extended read data.
REQ-013 Port resp_err, output, 1: request rejected; valid only with resp_valid.
REQ-014 Port mem_enable, output, 1: data RAM Enable.
REQ-015 Port mem_rw, output, 1: data RAM ReadWrite (0 = read, 1 = write).
REQ-016 Port mem_addr, output, 32: data RAM Address.
REQ-017 Port mem_wdata, output, 32: data RAM DataIn.
REQ-018 Port mem_size, output, 2: data RAM Size.
REQ-019 Port mem_rdata, input, 32: data RAM DataOut, big-endian, right-aligned.

Function
REQ-020 States SHALL be IDLE, SETUP, STROBE, RELEASE and RESP; req_ready = 1 only in IDLE.
REQ-021 In IDLE, req_valid=1 SHALL accept the request; rw, addr, wdata, size and signed are latched at that edge, and later req_* changes are ignored until the next acceptance.
REQ-022 For an accepted legal request, SETUP (1 cycle) SHALL drive mem_addr, mem_rw, mem_size and mem_wdata with mem_enable=0.
REQ-023 Next, STROBE SHALL hold mem_enable=1 for exactly STROBE_CYCLES cycles; a 4-bit counter tracks the cycles.
REQ-024 RELEASE (1 cycle) SHALL hold mem_enable=0; for reads, mem_rdata is captured at the end of RELEASE.
REQ-025 mem_addr, mem_rw, mem_size and mem_wdata SHALL stay stable from SETUP through RELEASE.
REQ-026 RESP (1 cycle) SHALL assert resp_valid=1, and the FSM then returns to IDLE.
REQ-027 Numbering cycle 1 as the first cycle after acceptance, legal-request resp_valid SHALL occur in cycle STROBE_CYCLES+3; with the default this is cycle 4.
REQ-028 Read extension: byte uses mem_rdata[7:0] and halfword uses mem_rdata[15:0]; each is sign-extended if req_signed=1, else zero-extended. Word passes through unchanged and ignores req_signed.
REQ-029 For writes, resp_rdata SHALL be 0.
REQ-030 mem_wdata SHALL carry req_wdata with unused upper bits zeroed: byte [7:0], halfword [15:0].
REQ-031 An illegal request SHALL go IDLE->RESP with resp_err=1, resp_rdata=0 and no mem_enable pulse; resp_valid occurs in cycle 1.
REQ-032 resp_err SHALL be 0 for every legal access.
REQ-033 Between accesses, mem_enable SHALL be 0 and all other mem_* outputs hold their last values.

Reset
REQ-034 reset=1 at a rising edge SHALL force IDLE and clear the strobe counter.
REQ-035 That same edge SHALL set req_ready=1 and clear resp_valid, resp_err, resp_rdata, mem_enable, mem_rw, mem_addr, mem_wdata and mem_size to 0.
REQ-036 Reset mid-access SHALL drop mem_enable at that edge and produce no response.
REQ-037 A write whose strobe already began before reset is not rolled back.
REQ-038 While reset=1, req_valid is not accepted.

Configuration
REQ-039 With MEM_ACCESS_ALIGN_CHECK_EN defined, a request is illegal if any of these holds: size=11; halfword with addr[0]=1; word with addr[1:0]≠00; or the last byte address > 255.
REQ-040 Without MEM_ACCESS_ALIGN_CHECK_EN, only size=11 is illegal; all other requests perform the memory access.

Verification
REQ-041 Word read, addr 0x04, RAM bytes 4..7 = 12 34 56 78 -> mem_enable high cycle 2 only; resp_valid cycle 4; resp_rdata=0x12345678; resp_err=0.
REQ-042 Signed byte read, addr 0x00 containing 0xB5 -> resp_rdata=0xFFFFFFB5; repeated unsigned -> 0x000000B5.
REQ-043 Halfword write 0xFFD3 to addr 0x02, then halfword read of addr 0x02 -> mem_wdata=0x0000FFD3 during the write; read returns 0x0000FFD3 unsigned, 0xFFFFFFD3 signed.
REQ-044 Word read, addr 0x06 with macro defined -> resp_valid cycle 1, resp_err=1, mem_enable never high; without the macro -> normal access, resp_err=0.
REQ-045 STROBE_CYCLES=3, word write 0xE35D8AC5 to addr 0x08, reset asserted in cycle 3 -> mem_enable=0 from the next cycle, no resp_valid, req_ready=1 after reset.
REQ-046 Back-to-back requests with req_valid held high -> the second is accepted only in the cycle after RESP; req_ready=0 throughout the first access.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Sequencer between a CPU load/store port and a strobed data RAM (setup, enable pulse, release, respond).
// Optional build macro MEM_ACCESS_ALIGN_CHECK_EN adds alignment and 256-byte range checks on requests.
module mem_access_ctrl #(
    parameter int unsigned STROBE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_enable,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    input  logic [31:0] mem_rdata
);

    // state   | meaning
    // IDLE    | ready for a request, mem_enable low
    // SETUP   | address/control/data driven, enable still low
    // STROBE  | mem_enable high for STROBE_CYCLES cycles
    // RELEASE | enable low again; read data captured on exit
    // RESP    | one-cycle resp_valid pulse
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, RESP} state_t;

    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

    state_t     state;
    logic [3:0] strobe_cnt;
    logic       signed_q;
    logic       req_legal;

    always_comb begin
        req_legal = (req_size != 2'b11);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        begin
            logic [32:0] last_byte;
            last_byte = {1'b0, req_addr};
            case (req_size)
                2'b01: begin
                    if (req_addr[0]) req_legal = 1'b0;
                    last_byte = {1'b0, req_addr} + 33'd1;
                end
                2'b10: begin
                    if (req_addr[1:0] != 2'b00) req_legal = 1'b0;
                    last_byte = {1'b0, req_addr} + 33'd3;
                end
                default: last_byte = {1'b0, req_addr};
            endcase
            if (last_byte > 33'd255) req_legal = 1'b0;
        end
`endif
    end

    function automatic logic [31:0] mask_wdata(input logic [31:0] data, input logic [1:0] size);
        case (size)
            2'b00:   mask_wdata = {24'h0, data[7:0]};
            2'b01:   mask_wdata = {16'h0, data[15:0]};
            default: mask_wdata = data;
        endcase
    endfunction

    function automatic logic [31:0] extend_rdata(input logic [31:0] data, input logic [1:0] size,
                                                 input logic sgn);
        case (size)
            2'b00:   extend_rdata = {{24{sgn & data[7]}}, data[7:0]};
            2'b01:   extend_rdata = {{16{sgn & data[15]}}, data[15:0]};
            default: extend_rdata = data;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            strobe_cnt <= 4'd0;
            signed_q   <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            mem_enable <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_size   <= 2'b00;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        signed_q  <= req_signed;
                        if (req_legal) begin
                            mem_rw    <= req_rw;
                            mem_addr  <= req_addr;
                            mem_size  <= req_size;
                            mem_wdata <= mask_wdata(req_wdata, req_size);
                            state     <= SETUP;
                        end else begin
                            // rejected requests never touch the RAM pins
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                            state      <= RESP;
                        end
                    end
                end
                SETUP: begin
                    mem_enable <= 1'b1;
                    strobe_cnt <= STROBE_LOAD;
                    state      <= STROBE;
                end
                STROBE: begin
                    if (strobe_cnt == 4'd0) begin
                        mem_enable <= 1'b0;
                        state      <= RELEASE;
                    end else begin
                        strobe_cnt <= strobe_cnt - 4'd1;
                    end
                end
                RELEASE: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= mem_rw ? 32'h0 : extend_rdata(mem_rdata, mem_size, signed_q);
                    state      <= RESP;
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    mem_enable <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed scoreboard bench for mem_access_ctrl: a default-strobe instance with a big-endian RAM
// model, plus a STROBE_CYCLES=3 instance for the mid-access reset case.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, reset_b, req_valid_a, req_valid_b;
    logic        req_rw, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    logic        req_ready_a, resp_valid_a, resp_err_a, mem_enable_a, mem_rw_a;
    logic [31:0] resp_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic [1:0]  mem_size_a;
    logic        req_ready_b, resp_valid_b, resp_err_b, mem_enable_b, mem_rw_b;
    logic [31:0] resp_rdata_b, mem_addr_b, mem_wdata_b;
    logic [31:0] mem_rdata_b = 32'h0;
    logic [1:0]  mem_size_b;

    mem_access_ctrl dut_a (
        .clk(clk), .reset(reset_a), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_signed(req_signed), .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a),
        .resp_err(resp_err_a), .mem_enable(mem_enable_a), .mem_rw(mem_rw_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_size(mem_size_a),
        .mem_rdata(mem_rdata_a)
    );

    mem_access_ctrl #(.STROBE_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_signed(req_signed), .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b),
        .resp_err(resp_err_b), .mem_enable(mem_enable_b), .mem_rw(mem_rw_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_size(mem_size_b),
        .mem_rdata(mem_rdata_b)
    );

    // Big-endian, right-aligned byte RAM, 256 bytes, address wraps on addr[7:0]
    logic [7:0] ram [0:255];
    logic [7:0] ra;

    always @(posedge clk) begin
        if (reset_a) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
            ram[0] <= 8'hB5;
            ram[4] <= 8'h12; ram[5] <= 8'h34; ram[6] <= 8'h56; ram[7] <= 8'h78;
        end else if (mem_enable_a && mem_rw_a) begin
            case (mem_size_a)
                2'b00: ram[mem_addr_a[7:0]] <= mem_wdata_a[7:0];
                2'b01: begin
                    ram[mem_addr_a[7:0]]         <= mem_wdata_a[15:8];
                    ram[mem_addr_a[7:0] + 8'd1]  <= mem_wdata_a[7:0];
                end
                default: begin
                    ram[mem_addr_a[7:0]]         <= mem_wdata_a[31:24];
                    ram[mem_addr_a[7:0] + 8'd1]  <= mem_wdata_a[23:16];
                    ram[mem_addr_a[7:0] + 8'd2]  <= mem_wdata_a[15:8];
                    ram[mem_addr_a[7:0] + 8'd3]  <= mem_wdata_a[7:0];
                end
            endcase
        end
    end

    always_comb begin
        ra = mem_addr_a[7:0];
        mem_rdata_a = 32'h0;
        case (mem_size_a)
            2'b00:   mem_rdata_a = {24'h0, ram[ra]};
            2'b01:   mem_rdata_a = {16'h0, ram[ra], ram[ra + 8'd1]};
            default: mem_rdata_a = {ram[ra], ram[ra + 8'd1], ram[ra + 8'd2], ram[ra + 8'd3]};
        endcase
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          strobes;
        logic        rw;
        logic [31:0] wdata;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_access(input string tag, input logic rw, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size, input logic sgn,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input logic [31:0] exp_wdata);
        exp_t e;
        int n, cyc, en_cnt, rdy_cnt;
        logic got;
        logic [31:0] wd_seen;
        @(negedge clk);
        req_valid_a = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wdata;
        req_size = size; req_signed = sgn;
        n = 0;
        while (!req_ready_a && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_ready"}, {31'h0, req_ready_a}, 32'h1);
        e.rdata = exp_rdata; e.err = exp_err; e.rw = rw; e.wdata = exp_wdata;
        e.lat = exp_err ? 1 : 4;
        e.strobes = exp_err ? 0 : 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        // scramble inputs after acceptance; the controller must work from its latched copy
        req_valid_a = 1'b0; req_rw = ~rw; req_addr = $urandom; req_wdata = $urandom;
        req_signed = ~sgn; req_size = $urandom_range(0, 3);
        cyc = 0; en_cnt = 0; rdy_cnt = 0; got = 1'b0; wd_seen = 32'h0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_enable_a) begin en_cnt++; wd_seen = mem_wdata_a; end
            if (req_ready_a) rdy_cnt++;
            if (resp_valid_a) got = 1'b1;
        end
        chk({tag, "_resp_seen"}, {31'h0, got}, 32'h1);
        e = sb.pop_front();
        chk({tag, "_latency"}, cyc, e.lat);
        chk({tag, "_err"}, {31'h0, resp_err_a}, {31'h0, e.err});
        chk({tag, "_rdata"}, resp_rdata_a, e.rdata);
        chk({tag, "_strobes"}, en_cnt, e.strobes);
        chk({tag, "_busy"}, rdy_cnt, 0);
        if (e.rw && !e.err) chk({tag, "_wdata"}, wd_seen, e.wdata);
        @(negedge clk);
        chk({tag, "_pulse"}, {31'h0, resp_valid_a}, 32'h0);
        chk({tag, "_idle"}, {31'h0, req_ready_a}, 32'h1);
    endtask

    initial begin
        int resp_cnt, rdy_cnt, first_rdy, en_cnt;
        int resp_cyc [2];
        exp_t e;

        reset_a = 1'b1; reset_b = 1'b1;
        req_valid_a = 1'b1; req_valid_b = 1'b1;
        req_rw = 1'b1; req_addr = 32'h44; req_wdata = 32'hDEADBEEF; req_size = 2'b10;
        req_signed = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'h0, req_ready_a}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid_a}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err_a}, 32'h0);
        chk("rst_resp_rdata", resp_rdata_a, 32'h0);
        chk("rst_mem_enable", {31'h0, mem_enable_a}, 32'h0);
        chk("rst_mem_rw", {31'h0, mem_rw_a}, 32'h0);
        chk("rst_mem_addr", mem_addr_a, 32'h0);
        chk("rst_mem_wdata", mem_wdata_a, 32'h0);
        chk("rst_mem_size", {30'h0, mem_size_a}, 32'h0);
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        reset_a = 1'b0; reset_b = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'h0, req_ready_a}, 32'h1);

        run_access("word_rd_04", 1'b0, 32'h04, 32'h0, 2'b10, 1'b0, 32'h12345678, 1'b0, 32'h0);
        run_access("byte_rd_s", 1'b0, 32'h00, 32'h0, 2'b00, 1'b1, 32'hFFFFFFB5, 1'b0, 32'h0);
        run_access("byte_rd_u", 1'b0, 32'h00, 32'h0, 2'b00, 1'b0, 32'h000000B5, 1'b0, 32'h0);
        run_access("hw_wr_02", 1'b1, 32'h02, 32'hABCDFFD3, 2'b01, 1'b0, 32'h0, 1'b0, 32'h0000FFD3);
        run_access("hw_rd_u", 1'b0, 32'h02, 32'h0, 2'b01, 1'b0, 32'h0000FFD3, 1'b0, 32'h0);
        run_access("hw_rd_s", 1'b0, 32'h02, 32'h0, 2'b01, 1'b1, 32'hFFFFFFD3, 1'b0, 32'h0);
        run_access("hw_rd_pos_s", 1'b0, 32'h04, 32'h0, 2'b01, 1'b1, 32'h00001234, 1'b0, 32'h0);
        run_access("size11", 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 32'h0);
        run_access("byte_wr_10", 1'b1, 32'h10, 32'h123456A7, 2'b00, 1'b1, 32'h0, 1'b0, 32'h000000A7);
        run_access("word_rd_10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b1, 32'hA7000000, 1'b0, 32'h0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        run_access("word_rd_06", 1'b0, 32'h06, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0);
        run_access("word_rd_100", 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0);
        run_access("word_rd_fc", 1'b0, 32'hFC, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0);
`else
        run_access("word_rd_06", 1'b0, 32'h06, 32'h0, 2'b10, 1'b0, 32'h56780000, 1'b0, 32'h0);
        run_access("word_rd_100", 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 32'hB500FFD3, 1'b0, 32'h0);
`endif

        // back-to-back: req_valid held high across two word reads
        @(negedge clk);
        req_valid_a = 1'b1; req_rw = 1'b0; req_addr = 32'h04; req_size = 2'b10; req_signed = 1'b0;
        e.rdata = 32'h12345678; e.err = 1'b0; e.lat = 4; e.strobes = 1; e.rw = 1'b0; e.wdata = 32'h0;
        sb.push_back(e);
        sb.push_back(e);
        @(posedge clk);
        resp_cnt = 0; rdy_cnt = 0; first_rdy = 0;
        resp_cyc[0] = 0; resp_cyc[1] = 0;
        for (int c = 1; c <= 14 && resp_cnt < 2; c++) begin
            @(negedge clk);
            if (req_ready_a) begin
                rdy_cnt++;
                if (first_rdy == 0) first_rdy = c;
            end
            if (resp_valid_a) begin
                resp_cyc[resp_cnt] = c;
                e = sb.pop_front();
                chk("b2b_rdata", resp_rdata_a, e.rdata);
                resp_cnt++;
                if (resp_cnt == 2) req_valid_a = 1'b0;
            end
        end
        req_valid_a = 1'b0;
        chk("b2b_resp_count", resp_cnt, 2);
        chk("b2b_first_resp", resp_cyc[0], 4);
        chk("b2b_ready_cycle", first_rdy, 5);
        chk("b2b_ready_count", rdy_cnt, 1);
        chk("b2b_second_resp", resp_cyc[1], 9);

        // mid-access reset on the STROBE_CYCLES=3 instance
        @(negedge clk);
        chk("b_ready", {31'h0, req_ready_b}, 32'h1);
        req_valid_b = 1'b1; req_rw = 1'b1; req_addr = 32'h08; req_wdata = 32'hE35D8AC5;
        req_size = 2'b10; req_signed = 1'b0;
        @(posedge clk);
        #1 req_valid_b = 1'b0;
        @(negedge clk);
        chk("b_c1_enable", {31'h0, mem_enable_b}, 32'h0);
        chk("b_c1_addr", mem_addr_b, 32'h08);
        @(negedge clk);
        chk("b_c2_enable", {31'h0, mem_enable_b}, 32'h1);
        chk("b_c2_wdata", mem_wdata_b, 32'hE35D8AC5);
        @(negedge clk);
        chk("b_c3_enable", {31'h0, mem_enable_b}, 32'h1);
        reset_b = 1'b1;
        @(negedge clk);
        chk("b_rst_enable", {31'h0, mem_enable_b}, 32'h0);
        chk("b_rst_ready", {31'h0, req_ready_b}, 32'h1);
        chk("b_rst_addr", mem_addr_b, 32'h0);
        reset_b = 1'b0;
        resp_cnt = 0; en_cnt = 0;
        if (resp_valid_b) resp_cnt++;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid_b) resp_cnt++;
            if (mem_enable_b) en_cnt++;
        end
        chk("b_no_resp", resp_cnt, 0);
        chk("b_no_enable", en_cnt, 0);
        chk("b_ready_after", {31'h0, req_ready_b}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
